fmul32_arbiter: RTL

FMUL32_ARBITER -- requirements
Module: fmul32_arbiter

---
 rtl/fmul32_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 34 +++
 rtl/fmul32_arbiter.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/fmul32_pkg.sv
// Shared widths and helpers for the FMUL32 request arbiter.
package fmul32_pkg;

    localparam int unsigned FP_W  = 32;
    localparam int unsigned CNT_W = 16;

    typedef logic [FP_W-1:0]  fp32_t;
    typedef logic [CNT_W-1:0] cnt_t;

    // Requester ID width; never narrower than one bit.
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first active request found
// searching upward from (ptr_i + 1) mod NUM_REQ, wrapping past NUM_REQ-1.
module rr_arbiter
    import fmul32_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IdW     = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IdW-1:0]     ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IdW-1:0]     idx_o,
    output logic               any_o
);

    logic [31:0] cand;

    // Priority search beginning just after the last granted requester.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        cand  = '0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            cand = (32'(ptr_i) + off) % NUM_REQ;
            if (!any_o && req_i[cand]) begin
                gnt_o[cand] = 1'b1;
                idx_o       = IdW'(cand);
                any_o       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fmul32_arbiter.sv
// Shares one fixed-latency FMUL32 core among NUM_REQ requesters.
// Operands are registered on handshake and issued the next cycle; owner IDs
// ride a LAT-deep shift register so each result is steered back in order.
// Optional feature: define FMUL32_ARB_GRANT_CNT_EN to add per-requester
// 16-bit handshake counters on output grant_cnt.
module fmul32_arbiter
    import fmul32_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned LAT     = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*FP_W-1:0]  req_a,
    input  logic [NUM_REQ*FP_W-1:0]  req_b,
    output logic                     core_issue,
    output logic [FP_W-1:0]          core_a,
    output logic [FP_W-1:0]          core_b,
    input  logic [FP_W-1:0]          core_res,
    output logic [NUM_REQ-1:0]       rsp_valid,
    output logic [FP_W-1:0]          rsp_data
`ifdef FMUL32_ARB_GRANT_CNT_EN
    ,
    output logic [NUM_REQ*CNT_W-1:0] grant_cnt
`endif
);

    localparam int unsigned IdW = id_width(NUM_REQ);

    logic [NUM_REQ-1:0] gnt;
    logic [IdW-1:0]     gnt_idx;
    logic               hs;

    logic [IdW-1:0] last_grant_q, last_grant_d;
    logic           issue_q, issue_d;
    logic [IdW-1:0] issue_id_q, issue_id_d;
    fp32_t          core_a_q, core_a_d;
    fp32_t          core_b_q, core_b_d;

    // Owner tracking: stage k holds the ID whose result arrives k+1 cycles
    // after issue; the last stage lines up with core_res.
    logic [LAT-1:0] vld_q, vld_d;
    logic [IdW-1:0] id_q [LAT];
    logic [IdW-1:0] id_d [LAT];

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IdW     (IdW)
    ) u_rr_arbiter (
        .req_i (req_valid),
        .ptr_i (last_grant_q),
        .gnt_o (gnt),
        .idx_o (gnt_idx),
        .any_o (hs)
    );

    // A grant always coincides with a valid request, so grant == handshake.
    assign req_ready  = gnt & {NUM_REQ{rst_n}};
    assign core_issue = issue_q;
    assign core_a     = core_a_q;
    assign core_b     = core_b_q;

    // Capture the granted operands and advance the round-robin pointer.
    always_comb begin
        last_grant_d = last_grant_q;
        issue_d      = hs;
        issue_id_d   = gnt_idx;
        core_a_d     = core_a_q;
        core_b_d     = core_b_q;
        if (hs) begin
            last_grant_d = gnt_idx;
            core_a_d     = req_a[32'(gnt_idx)*FP_W +: FP_W];
            core_b_d     = req_b[32'(gnt_idx)*FP_W +: FP_W];
        end
    end

    // Issue-stage registers and arbitration pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= IdW'(NUM_REQ - 1);
            issue_q      <= 1'b0;
            issue_id_q   <= '0;
            core_a_q     <= '0;
            core_b_q     <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            issue_q      <= issue_d;
            issue_id_q   <= issue_id_d;
            core_a_q     <= core_a_d;
            core_b_q     <= core_b_d;
        end
    end

    // Shift the owner ID pipeline every cycle; the core never stalls.
    always_comb begin
        vld_d[0] = issue_q;
        id_d[0]  = issue_id_q;
        for (int unsigned k = 1; k < LAT; k++) begin
            vld_d[k] = vld_q[k-1];
            id_d[k]  = id_q[k-1];
        end
    end

    // Owner ID pipeline registers; reset drops all in-flight operations.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int unsigned k = 0; k < LAT; k++) begin
                id_q[k] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            for (int unsigned k = 0; k < LAT; k++) begin
                id_q[k] <= id_d[k];
            end
        end
    end

    // Steer the core result to its owner; data reads zero when idle.
    always_comb begin
        rsp_valid = '0;
        rsp_data  = '0;
        if (vld_q[LAT-1]) begin
            rsp_valid[id_q[LAT-1]] = 1'b1;
            rsp_data               = core_res;
        end
    end

`ifdef FMUL32_ARB_GRANT_CNT_EN
    cnt_t cnt_q [NUM_REQ];
    cnt_t cnt_d [NUM_REQ];

    // Per-requester handshake counts, wrapping naturally at 16 bits.
    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cnt_d[i] = gnt[i] ? cnt_q[i] + cnt_t'(1) : cnt_q[i];
            grant_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
        end
    end

    // Handshake counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end
`endif

endmodule
